// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side responder for load/store requests. It accepts one
//               request at a time over a valid/ready handshake and holds it
//               for LATENCY cycles. It then commits the store or performs the
//               load, and returns the response over a second valid/ready
//               handshake. Word storage is byte-lane addressable.
// Ports       : clk, rst                 clock / synchronous active-high reset
//               req_valid, req_ready     request handshake
//               req_we, req_funct3       store flag, RV32 size code
//               req_addr, req_wdata      byte address, right-aligned store data
//               rsp_valid, rsp_ready     response handshake
//               rsp_rdata, rsp_err       extended load data, error flag
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int WIDTH       = 32,    // datapath is RV32; lane logic assumes 32
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2      // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int         c_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_LOAD   = 4'(LATENCY - 1);
    localparam logic       c_DIRECT = (LATENCY == 1);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_cnt;

    logic             r_we;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;

    logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_access;
    logic             w_acc_we;
    logic [2:0]       w_acc_f3;
    logic [WIDTH-1:0] w_acc_addr;
    logic [WIDTH-1:0] w_acc_wdata;
    logic             w_misaligned;
    logic             w_illegal;
    logic             w_out_of_range;
    logic             w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [WIDTH-1:0] w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_load_data;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_commit;

    // ------------------------------------------------------------------
    // Handshake outputs and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    w_next_state = c_DIRECT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The counter reaches 0 at this edge: access happens now.
                if (r_cnt == 4'd1) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_accept = req_valid && req_ready;

    // The access happens either at the acceptance edge (LATENCY=1, using the
    // live request) or at the last WAIT edge (using the captured request).
    assign w_access = !rst &&
                      ((w_accept && c_DIRECT) ||
                       (r_state == ST_WAIT && r_cnt == 4'd1));

    always_comb begin
        w_acc_we    = r_we;
        w_acc_f3    = r_funct3;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        if (r_state == ST_IDLE) begin
            w_acc_we    = req_we;
            w_acc_f3    = req_funct3;
            w_acc_addr  = req_addr;
            w_acc_wdata = req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Request checks
    // ------------------------------------------------------------------
    assign w_misaligned = ((w_acc_f3 == c_F3_H || w_acc_f3 == c_F3_HU) && w_acc_addr[0]) ||
                          ((w_acc_f3 == c_F3_W) && (w_acc_addr[1:0] != 2'b00));

    assign w_illegal = (w_acc_f3 == 3'b011) || (w_acc_f3 == 3'b110) ||
                       (w_acc_f3 == 3'b111) ||
                       (w_acc_we && (w_acc_f3 == c_F3_BU || w_acc_f3 == c_F3_HU));

    assign w_out_of_range = (w_acc_addr[WIDTH-1:2] >= (WIDTH-2)'(DEPTH_WORDS));

    assign w_err = w_misaligned || w_illegal || w_out_of_range;

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    assign w_idx  = w_acc_addr[c_IDX_W+1:2];
    // Only consumed when the request is in range.
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_acc_addr[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign w_half = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = '0;
        case (w_acc_f3)
            c_F3_B:  w_load_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
            c_F3_BU: w_load_data = {{(WIDTH-8){1'b0}}, w_byte};
            c_F3_H:  w_load_data = {{(WIDTH-16){w_half[15]}}, w_half};
            c_F3_HU: w_load_data = {{(WIDTH-16){1'b0}}, w_half};
            c_F3_W:  w_load_data = w_word;
            default: w_load_data = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store path: replicate the right-aligned data across lanes and let
    // the byte enables pick which lanes actually change.
    // ------------------------------------------------------------------
    always_comb begin
        w_be      = 4'b0000;
        w_wr_data = w_acc_wdata;
        case (w_acc_f3)
            c_F3_B: begin
                w_be      = 4'b0001 << w_acc_addr[1:0];
                w_wr_data = {4{w_acc_wdata[7:0]}};
            end
            c_F3_H: begin
                w_be      = w_acc_addr[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{w_acc_wdata[15:0]}};
            end
            c_F3_W: begin
                w_be      = 4'b1111;
                w_wr_data = w_acc_wdata;
            end
            default: begin
                w_be      = 4'b0000;
                w_wr_data = w_acc_wdata;
            end
        endcase
    end

    assign w_commit = w_access && w_acc_we && !w_err;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State, counter, capture and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_cnt    <= c_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                rsp_err   <= w_err;
                rsp_rdata <= (w_err || w_acc_we) ? '0 : w_load_data;
            end
        end
    end

endmodule
`default_nettype wire
